// File: rtl/uart_disk_ctrl_if.sv
// CPU buffer/command port plus byte-engine handshake for the UART disk controller.
// The slave modport is the controller; the master is its environment (CPU and UART engine).
// Pure wiring: no state, no latency.
interface uart_disk_ctrl_if #(
  parameter int ADDR_W = 9
);
  // CPU side
  logic [ADDR_W-1:0] buf_addr;
  logic [31:0]       buf_wdata;
  logic              buf_we;
  logic [31:0]       buf_rdata;
  logic              cmd_valid;
  logic              cmd_write;
  logic [28:0]       cmd_lba;
  logic              cmd_ready;
  logic              busy;
  logic              done;
  logic              error;
  // UART byte engine side
  logic              uart_en;
  logic              uart_we;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_done;
  logic              uart_rx_done;
  logic [7:0]        uart_rx_data;

  modport slave (
    input  buf_addr, buf_wdata, buf_we, cmd_valid, cmd_write, cmd_lba,
           uart_tx_done, uart_rx_done, uart_rx_data,
    output buf_rdata, cmd_ready, busy, done, error,
           uart_en, uart_we, uart_tx_data
  );

  modport master (
    output buf_addr, buf_wdata, buf_we, cmd_valid, cmd_write, cmd_lba,
           uart_tx_done, uart_rx_done, uart_rx_data,
    input  buf_rdata, cmd_ready, busy, done, error,
           uart_en, uart_we, uart_tx_data
  );
endinterface

// File: rtl/uart_disk_ctrl.sv
// UART-tunnelled disk controller: one-sector buffer, REQ/HELLO/DATA/BYE byte protocol with retry.
// Latency: first request byte one cycle after accept; one idle gap cycle after each byte.
// Backpressure: cmd_ready = ~busy; CPU buffer writes dropped while busy. Optional UART_DISK_CHECKSUM_EN adds an XOR checksum byte.
module uart_disk_ctrl #(
  parameter int SECTOR_BYTES = 512,
  parameter int ADDR_W       = 9,
  parameter int MAX_RETRY    = 3,
  parameter int TIMEOUT_CYC  = 100000
) (
  input  logic             clk,
  input  logic             rst,
  uart_disk_ctrl_if.slave  bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_HELLO, S_DATA, S_CSUM, S_BYE, S_GAP
  } state_t;

  state_t            state;
  state_t            ret_state;   // where GAP goes next
  logic [31:0]       req_word;
  logic              wr_mode;
  logic [CNT_W-1:0]  byte_cnt;
  logic [RTY_W-1:0]  retry_cnt;
  logic [TMR_W-1:0]  timer;
  logic [7:0]        csum;
  logic [7:0]        mem [SECTOR_BYTES];

  logic              busy_q, done_q, error_q, en_q, we_q;
  logic [7:0]        tx_q;

  logic              active, ev, timeout, nak, csum_bad, fail, last_retry;
  logic              cpu_store, rx_store;
  logic [7:0]        xfer_byte;
  logic [ADDR_W-1:0] mem_idx;
  logic [ADDR_W-3:0] word_base;
  logic              unused_addr_lsb;

  assign bus.busy         = busy_q;
  assign bus.cmd_ready    = ~busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.uart_en      = en_q;
  assign bus.uart_we      = we_q;
  assign bus.uart_tx_data = tx_q;

  // Word-aligned CPU access: the two low address bits are don't-care.
  assign word_base       = bus.buf_addr[ADDR_W-1:2];
  assign unused_addr_lsb = ^bus.buf_addr[1:0];
  assign bus.buf_rdata   = {mem[{word_base, 2'd3}], mem[{word_base, 2'd2}],
                            mem[{word_base, 2'd1}], mem[{word_base, 2'd0}]};

  // A done pulse only counts when it matches the current transfer direction.
  assign active    = (state != S_IDLE) && (state != S_GAP);
  assign ev        = active && en_q &&
                     ((bus.uart_tx_done && we_q) || (bus.uart_rx_done && !we_q));
  assign timeout   = active && !ev && (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign nak       = (state == S_HELLO) && ev && (bus.uart_rx_data != 8'hFF);
`ifdef UART_DISK_CHECKSUM_EN
  assign csum_bad  = (state == S_CSUM) && ev && !wr_mode && (bus.uart_rx_data != csum);
`else
  assign csum_bad  = 1'b0;
`endif
  assign fail       = timeout || nak || csum_bad;
  assign last_retry = (int'(retry_cnt) >= MAX_RETRY);
  assign xfer_byte  = we_q ? tx_q : bus.uart_rx_data;
  assign mem_idx    = byte_cnt[ADDR_W-1:0];
  assign cpu_store  = bus.buf_we && (state == S_IDLE) && !rst;
  assign rx_store   = (state == S_DATA) && ev && !wr_mode && !rst;

  // Sector buffer: CPU owns it in IDLE, the FSM fills it during a read's DATA phase.
  always_ff @(posedge clk) begin
    if (cpu_store) begin
      mem[{word_base, 2'd0}] <= bus.buf_wdata[7:0];
      mem[{word_base, 2'd1}] <= bus.buf_wdata[15:8];
      mem[{word_base, 2'd2}] <= bus.buf_wdata[23:16];
      mem[{word_base, 2'd3}] <= bus.buf_wdata[31:24];
    end else if (rx_store) begin
      mem[mem_idx] <= bus.uart_rx_data;
    end
  end

  // Protocol FSM; every completed byte passes through GAP, which sets up the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      req_word  <= '0;
      wr_mode   <= 1'b0;
      byte_cnt  <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      csum      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      tx_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (active) timer <= ev ? '0 : timer + 1'b1;

      if (fail) begin
        if (last_retry) begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          error_q <= 1'b1;
          en_q    <= 1'b0;
          we_q    <= 1'b0;
        end else begin
          retry_cnt <= retry_cnt + 1'b1;
          byte_cnt  <= '0;
          ret_state <= S_REQ;
          state     <= S_GAP;
          en_q      <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.cmd_valid) begin
              wr_mode   <= bus.cmd_write;
              req_word  <= {1'b1, bus.cmd_write, 1'b1, bus.cmd_lba};
              busy_q    <= 1'b1;
              error_q   <= 1'b0;
              en_q      <= 1'b1;
              we_q      <= 1'b1;
              tx_q      <= bus.cmd_lba[7:0];
              byte_cnt  <= '0;
              retry_cnt <= '0;
              timer     <= '0;
              state     <= S_REQ;
            end
          end
          S_GAP: begin
            state <= ret_state;
            en_q  <= 1'b1;
            timer <= '0;
            case (ret_state)
              S_REQ: begin
                we_q <= 1'b1;
                tx_q <= req_word[{byte_cnt[1:0], 3'b000} +: 8];
              end
              S_HELLO: we_q <= 1'b0;
              S_DATA: begin
                we_q <= wr_mode;
                if (wr_mode) tx_q <= mem[mem_idx];
              end
              S_CSUM: begin
                we_q <= wr_mode;
                if (wr_mode) tx_q <= csum;
              end
              S_BYE: begin
                we_q <= 1'b1;
                tx_q <= 8'hFF;
              end
              default: begin
                state  <= S_IDLE;
                en_q   <= 1'b0;
                busy_q <= 1'b0;
              end
            endcase
          end
          S_REQ: begin
            if (ev) begin
              en_q  <= 1'b0;
              state <= S_GAP;
              if (byte_cnt[1:0] == 2'd3) begin
                ret_state <= S_HELLO;
              end else begin
                byte_cnt  <= byte_cnt + 1'b1;
                ret_state <= S_REQ;
              end
            end
          end
          S_HELLO: begin
            if (ev) begin
              en_q      <= 1'b0;
              state     <= S_GAP;
              ret_state <= S_DATA;
              byte_cnt  <= '0;
              csum      <= '0;
            end
          end
          S_DATA: begin
            if (ev) begin
              en_q     <= 1'b0;
              state    <= S_GAP;
              csum     <= csum ^ xfer_byte;
              byte_cnt <= byte_cnt + 1'b1;
              if ((byte_cnt + 1'b1) == CNT_W'(SECTOR_BYTES)) begin
`ifdef UART_DISK_CHECKSUM_EN
                ret_state <= S_CSUM;
`else
                ret_state <= S_BYE;
`endif
              end else begin
                ret_state <= S_DATA;
              end
            end
          end
          S_CSUM: begin
            if (ev) begin
              en_q      <= 1'b0;
              state     <= S_GAP;
              ret_state <= S_BYE;
            end
          end
          S_BYE: begin
            if (ev) begin
              state   <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              error_q <= 1'b0;
              en_q    <= 1'b0;
              we_q    <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_disk_ctrl.sv
// Bench for uart_disk_ctrl: plays CPU and UART byte engine, scoreboards transmitted bytes.
// Small sector (16 bytes) and short timeout (50 cycles) keep runs brief.
// Expected tx bytes are queued at command issue and popped as the DUT transmits.
module tb_uart_disk_ctrl;
  localparam int SB = 16;
  localparam int AW = 4;
  localparam int MR = 3;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_disk_ctrl_if #(.ADDR_W(AW)) bus ();

  uart_disk_ctrl #(
    .SECTOR_BYTES(SB), .ADDR_W(AW), .MAX_RETRY(MR), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model [SB];
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input int a);
    return {model[a+3], model[a+2], model[a+1], model[a]};
  endfunction

  function automatic logic [7:0] model_xor();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < SB; i++) x ^= model[i];
    return x;
  endfunction

  task automatic read_word(input int a, output logic [31:0] d);
    bus.buf_addr = AW'(a);
    #1;
    d = bus.buf_rdata;
  endtask

  task automatic cpu_write(input int a, input logic [31:0] d);
    bus.buf_addr  = AW'(a);
    bus.buf_wdata = d;
    bus.buf_we    = 1'b1;
    tick();
    bus.buf_we    = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [28:0] lba);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_lba   = lba;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_req(input logic wr, input logic [28:0] lba);
    logic [31:0] w;
    w = {1'b1, wr, 1'b1, lba};
    for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic push_write_data();
    for (int i = 0; i < SB; i++) exp_q.push_back(model[i]);
`ifdef UART_DISK_CHECKSUM_EN
    exp_q.push_back(model_xor());
`endif
  endtask

  // Accept one transmitted byte from the DUT and compare against the scoreboard.
  task automatic host_tx(input string tag);
    int t = 0;
    while (!(bus.uart_en && bus.uart_we) && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      check({tag, "_wait"}, 32'd0, 32'd1);
      return;
    end
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check(tag, {24'd0, bus.uart_tx_data}, {24'd0, exp_q.pop_front()});
    bus.uart_tx_done = 1'b1;
    tick();
    bus.uart_tx_done = 1'b0;
    check({tag, "_gap"}, {31'd0, bus.uart_en}, 32'd0);
  endtask

  // Deliver one received byte to the DUT.
  task automatic host_rx(input logic [7:0] b, input string tag);
    int t = 0;
    while (!(bus.uart_en && !bus.uart_we) && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      check({tag, "_wait"}, 32'd0, 32'd1);
      return;
    end
    bus.uart_rx_data = b;
    bus.uart_rx_done = 1'b1;
    tick();
    bus.uart_rx_done = 1'b0;
    check({tag, "_gap"}, {31'd0, bus.uart_en}, 32'd0);
  endtask

  task automatic wait_done(input logic exp_err, input string tag, output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 2000) begin
      tick();
      cyc++;
    end
    if (cyc >= 2000) begin
      check({tag, "_done_wait"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_err"}, {31'd0, bus.error}, {31'd0, exp_err});
    check({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_sb_drain"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_error"}, {31'd0, bus.error}, 32'd0);
    check({tag, "_en"}, {31'd0, bus.uart_en}, 32'd0);
    check({tag, "_we"}, {31'd0, bus.uart_we}, 32'd0);
    check({tag, "_txd"}, {24'd0, bus.uart_tx_data}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          cyc;
    int          edges;
    logic        prev_en;
    logic        stray;

    bus.buf_addr = '0;  bus.buf_wdata = '0;  bus.buf_we = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_lba = '0;
    bus.uart_tx_done = 1'b0; bus.uart_rx_done = 1'b0; bus.uart_rx_data = '0;

    // Reset state
    repeat (3) tick();
    check_idle_outputs("rst");
    rst = 1'b0;
    tick();
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    for (int i = 0; i < SB; i++) model[i] = 8'h00;
    for (int a = 0; a < SB; a += 4) cpu_write(a, 32'h0);

    // Test 1: reset mid-DATA of a write leaves the buffer alone
    cpu_write(0, 32'h11223344);
    {model[3], model[2], model[1], model[0]} = 32'h11223344;
    read_word(0, d);
    check("t1_wr0", d, 32'h11223344);
    issue(1'b1, 29'd2);
    push_req(1'b1, 29'd2);
    exp_q.push_back(model[0]);
    exp_q.push_back(model[1]);
    for (int k = 0; k < 4; k++) host_tx("t1_req");
    host_rx(8'hFF, "t1_hello");
    host_tx("t1_d0");
    host_tx("t1_d1");
    rst = 1'b1;
    tick();
    tick();
    check_idle_outputs("t1_inrst");
    rst = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    check_idle_outputs("t1_after");
    check("t1_ready", {31'd0, bus.cmd_ready}, 32'd1);
    read_word(0, d);
    check("t1_buf0", d, 32'h11223344);

    // Test 2: read lba 5, host sends i
    issue(1'b0, 29'd5);
    push_req(1'b0, 29'd5);
    exp_q.push_back(8'hFF);
    for (int k = 0; k < 4; k++) host_tx("t2_req");
    tick();
    bus.uart_tx_done = 1'b1;   // spurious: DUT is receiving
    tick();
    bus.uart_tx_done = 1'b0;
    host_rx(8'hFF, "t2_hello");
    for (int i = 0; i < SB; i++) begin
      model[i] = 8'(i);
      host_rx(8'(i), "t2_data");
    end
`ifdef UART_DISK_CHECKSUM_EN
    host_rx(model_xor(), "t2_csum");
`endif
    host_tx("t2_bye");
    wait_done(1'b0, "t2", cyc);
    read_word(0, d);
    check("t2_buf0", d, 32'h03020100);
    read_word(12, d);
    check("t2_buf12", d, model_word(12));

    // Test 3: write lba 1 after CPU word at 4
    cpu_write(4, 32'hDEADBEEF);
    {model[7], model[6], model[5], model[4]} = 32'hDEADBEEF;
    issue(1'b1, 29'd1);
    push_req(1'b1, 29'd1);
    push_write_data();
    exp_q.push_back(8'hFF);
    for (int k = 0; k < 4; k++) host_tx("t3_req");
    host_rx(8'hFF, "t3_hello");
    for (int i = 0; i < SB; i++) host_tx("t3_data");
`ifdef UART_DISK_CHECKSUM_EN
    host_tx("t3_csum");
`endif
    host_tx("t3_bye");
    wait_done(1'b0, "t3", cyc);

    // Test 4: two NAKs then ack; REQ sent three times
    issue(1'b0, 29'd7);
    push_req(1'b0, 29'd7);
    push_req(1'b0, 29'd7);
    push_req(1'b0, 29'd7);
    exp_q.push_back(8'hFF);
    for (int k = 0; k < 4; k++) host_tx("t4_req_a");
    host_rx(8'h00, "t4_nak_a");
    for (int k = 0; k < 4; k++) host_tx("t4_req_b");
    host_rx(8'h00, "t4_nak_b");
    for (int k = 0; k < 4; k++) host_tx("t4_req_c");
    host_rx(8'hFF, "t4_hello");
    for (int i = 0; i < SB; i++) begin
      model[i] = 8'(i) ^ 8'h5A;
      host_rx(model[i], "t4_data");
    end
`ifdef UART_DISK_CHECKSUM_EN
    host_rx(model_xor(), "t4_csum");
`endif
    host_tx("t4_bye");
    wait_done(1'b0, "t4", cyc);
    read_word(4, d);
    check("t4_buf4", d, model_word(4));

    // Test 5: silent host -> four attempts, then error
    issue(1'b0, 29'd9);
    edges   = 0;
    prev_en = 1'b0;
    cyc     = 0;
    while (!bus.done && cyc < 1000) begin
      if (bus.uart_en && !prev_en) edges++;
      prev_en = bus.uart_en;
      tick();
      cyc++;
    end
    check("t5_done_seen", {31'd0, bus.done}, 32'd1);
    check("t5_attempts", edges, 32'd4);
    check("t5_err", {31'd0, bus.error}, 32'd1);
    check("t5_latency", {31'd0, (cyc >= 200 && cyc <= 260)}, 32'd1);
    tick();
    check("t5_err_sticky", {31'd0, bus.error}, 32'd1);
    check("t5_pulse", {31'd0, bus.done}, 32'd0);

    // Test 6: CPU write and command during busy are ignored
    issue(1'b1, 29'd3);
    check("t6_err_clr", {31'd0, bus.error}, 32'd0);
    check("t6_not_ready", {31'd0, bus.cmd_ready}, 32'd0);
    push_req(1'b1, 29'd3);
    push_write_data();
    exp_q.push_back(8'hFF);
    host_tx("t6_req");
    cpu_write(8, 32'hCAFEF00D);
    issue(1'b0, 29'h55);
    read_word(8, d);
    check("t6_buf8_busy", d, model_word(8));
    for (int k = 1; k < 4; k++) host_tx("t6_req");
    host_rx(8'hFF, "t6_hello");
    for (int i = 0; i < SB; i++) host_tx("t6_data");
`ifdef UART_DISK_CHECKSUM_EN
    host_tx("t6_csum");
`endif
    host_tx("t6_bye");
    wait_done(1'b0, "t6", cyc);
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy || bus.uart_en) stray = 1'b1;
      tick();
    end
    check("t6_no_second_cmd", {31'd0, stray}, 32'd0);
    read_word(8, d);
    check("t6_buf8_after", d, model_word(8));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
